key_event_ctrl: RTL

- Controller between the 4x4 matrix keypad scanner and the consumer logic (display, CPU bus, game FSM).
- Generates the scanner's scan-rate enable and converts the scanner's debounced 16-bit key-level vector into a queue of discrete press/release events.
- Keys that change in the same cycle are served by a round-robin arbiter, one event per cycle; a small FWFT FIFO supplies events through a valid/ready handshake.

---
 rtl/key_event_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/key_event_ctrl.sv
// Keypad event controller: scan-rate tick, btn synchronizer, round-robin change arbiter, FWFT event FIFO.
// Optional auto-repeat is compiled in with `define KEY_REPEAT_EN.
module key_event_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int FIFO_DEPTH   = 4,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          scan_en,
  input  logic [15:0]                   btn,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [5:0]                    evt_code,
  output logic [15:0]                   key_held,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [CW-1:0] scan_cnt;
  logic [15:0]   sync1, sync2, prev, chg;
  logic [3:0]    rr_ptr, sel, idx;
  logic          found;

  logic [5:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [5:0]    last_code, push_data;
  logic          full, empty, pop, push_ok, serve, rep_push, push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign scan_en = (scan_cnt == CW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  assign chg = sync2 ^ prev;

  // First pending change at or above rr_ptr, wrapping 15 -> 0.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < 16; i++) begin
      idx = rr_ptr + 4'(i);
      if (!found && chg[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign pop     = !empty && evt_ready;
  assign push_ok = !full || pop;
  assign serve   = found && push_ok;
  assign push    = serve || rep_push;

`ifdef KEY_REPEAT_EN
  logic [15:0] rep_cnt;
  logic        rep_phase, single, rep_fire;
  logic [3:0]  rep_idx;

  assign single = (prev != '0) && ((prev & (prev - 16'd1)) == '0);

  always_comb begin
    rep_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (prev[i]) rep_idx = 4'(i);
    end
  end

  assign rep_fire = single && (chg == '0) && scan_en &&
                    (rep_cnt == (rep_phase ? 16'(REPEAT_RATE - 1) : 16'(REPEAT_DELAY - 1)));
  // A repeat that cannot be pushed right now is simply lost.
  assign rep_push  = rep_fire && !found && push_ok;
  assign push_data = serve ? {1'b0, sync2[sel], sel} : {2'b11, rep_idx};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if (serve || !single) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
    end else if ((chg == '0) && scan_en) begin
      if (rep_fire) begin
        rep_cnt   <= '0;
        rep_phase <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + 16'd1;
      end
    end
  end
`else
  assign rep_push  = 1'b0;
  assign push_data = {1'b0, sync2[sel], sel};

  // Repeat timing has no meaning without the repeat logic.
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_repeat_timing_ignored
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= '0;
      rr_ptr <= '0;
    end else if (serve) begin
      prev[sel] <= sync2[sel];
      rr_ptr    <= sel + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // last_code keeps evt_code stable once the FIFO drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      last_code <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_code <= mem[rd_ptr];
      end
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  assign evt_valid  = !empty;
  assign evt_code   = empty ? last_code : mem[rd_ptr];
  assign key_held   = prev;
  assign fifo_level = level;

endmodule
